// File: rtl/rv_pkg.sv
// Shared RV32 pipeline definitions: funct3 load/store encodings, MEM-stage
// FSM states, the data-memory command payload and store lane helpers.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Payload presented on the data-memory request port
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } dmem_cmd_t;

  // Halfwords need an even address; words (and undefined size 11) need a
  // word-aligned address; bytes are always aligned
  function automatic logic access_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

  function automatic logic [BE_W-1:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return BE_W'(4'b0001 << off);
      2'b01:   return BE_W'(4'b0011 << off);
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store value across every lane so the byte enables pick it
  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the byte/halfword lane addressed by byte_off
// from the raw memory word and sign- or zero-extends it per funct3.
// Ports: rdata (raw word), funct3 (size/sign), byte_off (addr[1:0]),
//        load_data_c (combinational aligned result).
module mem_load_align
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  output logic [XLEN-1:0] load_data_c
);

  logic [15:0] lane;

  // Shift the addressed lane down to bit 0, then extend
  always_comb begin
    lane        = 16'(rdata >> {byte_off, 3'b000});
    load_data_c = rdata;
    case (funct3)
      F3_B:    load_data_c = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   load_data_c = {24'b0, lane[7:0]};
      F3_H:    load_data_c = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   load_data_c = {16'b0, lane[15:0]};
      default: load_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32 data-memory access stage between EX/MEM and MEM/WB.
// Issues aligned loads/stores on a req/ack port, stalls upstream while an
// access is outstanding, suppresses misaligned accesses and registers the
// writeback fields for MEM/WB.
// Ports: EX/MEM fields (in_valid, alu_result, rdata2, rd, en_write_reg,
//        en_mem_read, en_mem_write, write_source, funct3); stall (comb);
//        dmem_* request/response; wb_* writeback; misalign pulse.
module mem_stage
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [4:0]        rd,
  input  logic              en_write_reg,
  input  logic              en_mem_read,
  input  logic              en_mem_write,
  input  logic              write_source,
  input  logic [2:0]        funct3,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_en_write_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign
);

  mem_state_t  state;
  dmem_cmd_t   cmd_q;
  dmem_cmd_t   cmd_c;
  logic        mem_op;
  logic        aligned;
  logic [1:0]  off;
  logic [DATA_W-1:0] load_data_c;

  // Decode of the instruction currently held in EX/MEM
  always_comb begin
    off         = alu_result[1:0];
    mem_op      = en_mem_read | en_mem_write;
    aligned     = access_aligned(funct3, off);
    cmd_c       = '0;
    cmd_c.we    = en_mem_write;
    cmd_c.addr  = XLEN'({alu_result[ADDR_W-1:2], 2'b00});
    cmd_c.wdata = store_wdata(funct3, rdata2);
    cmd_c.be    = en_mem_write ? store_be(funct3, off) : 4'b0000;
  end

  // Hold upstream from acceptance until the ack cycle; inputs stay stable
  // throughout, so the ack cycle can read rd/funct3/etc. directly
  assign stall = in_valid & mem_op & aligned & ~((state == BUSY) & dmem_ack);

  assign dmem_we    = cmd_q.we;
  assign dmem_addr  = ADDR_W'(cmd_q.addr);
  assign dmem_wdata = cmd_q.wdata;
  assign dmem_be    = cmd_q.be;

  mem_load_align u_load_align (
    .rdata       (dmem_rdata),
    .funct3      (funct3),
    .byte_off    (off),
    .load_data_c (load_data_c)
  );

  // Access FSM with registered request and writeback outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      dmem_req        <= 1'b0;
      cmd_q           <= '0;
      wb_valid        <= 1'b0;
      wb_rd           <= 5'd0;
      wb_en_write_reg <= 1'b0;
      wb_data         <= '0;
      misalign        <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!mem_op) begin
              wb_valid        <= 1'b1;
              wb_rd           <= rd;
              wb_en_write_reg <= en_write_reg;
              wb_data         <= alu_result;
            end else if (!aligned) begin
              // Suppressed access still retires, but never writes the regfile
              wb_valid        <= 1'b1;
              wb_rd           <= rd;
              wb_en_write_reg <= 1'b0;
              wb_data         <= alu_result;
              misalign        <= 1'b1;
            end else begin
              dmem_req <= 1'b1;
              cmd_q    <= cmd_c;
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req        <= 1'b0;
            state           <= IDLE;
            wb_valid        <= 1'b1;
            wb_rd           <= rd;
            wb_en_write_reg <= en_write_reg;
            wb_data         <= (!cmd_q.we && write_source) ? load_data_c : alu_result;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Data-memory access stage of the RISC-V pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It takes the EX/MEM outputs, performs load/store accesses over a req/ack data-memory port with byte enables, and aligns and sign-extends load data. While an access is outstanding it stalls the upstream pipeline, and it presents registered writeback fields to MEM/WB.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width
- DATA_W, 32, data width; fixed at 32 (RV32)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  EX/MEM holds a valid instruction
- alu_result  in  32  ALU result, used as memory address and as ALU writeback data
- rdata2  in  32  store data
- rd  in  5  destination register
- en_write_reg  in  1  regfile write enable
- en_mem_read  in  1  load
- en_mem_write  in  1  store
- write_source  in  1  1 = writeback from memory, 0 = from ALU
- funct3  in  3  access size/sign
- stall  out  1  combinational; upstream must hold all inputs while high
- dmem_req  out  1  memory request (registered)
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({alu_result[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_rdata  in  32  read data, valid with dmem_ack
- dmem_ack  in  1  one-cycle completion pulse
- wb_valid  out  1  MEM/WB entry valid
- wb_rd  out  5  destination register
- wb_en_write_reg  out  1  regfile write enable
- wb_data  out  32  writeback value
- misalign  out  1  one-cycle pulse; misaligned access was suppressed

## Operation
- FSM states: IDLE, BUSY.
- IDLE, no memory op (in_valid & ~en_mem_read & ~en_mem_write):
  - Register wb_* next cycle.
  - wb_data = alu_result.
- IDLE, aligned memory op:
  - Next cycle: dmem_req=1, addr/we/be/wdata latched; go to BUSY.
  - stall=1 this cycle.
- BUSY:
  - Hold dmem_req and all dmem_* outputs stable until dmem_ack.
  - On the ack cycle, stall=0 so upstream advances.
  - Next cycle: dmem_req=0, wb_* valid, state returns to IDLE.
- stall = in_valid & mem_op & aligned & ~(state==BUSY & dmem_ack).
- en_mem_read and en_mem_write both set: treat as store.
- Alignment rules:
  - halfword (funct3[1:0]=01) requires addr[0]=0.
  - word (10, and undefined 11) requires addr[1:0]=0.
  - Misaligned op: no request; misalign=1 and wb_valid=1 with wb_en_write_reg=0 next cycle.
- Store data and enables:
  - sb: be = 0001<<addr[1:0], wdata = {4{rdata2[7:0]}}.
  - sh: be = 0011<<addr[1:0], wdata = {2{rdata2[15:0]}}.
  - sw: be = 1111, wdata = rdata2.
  - dmem_be = 0000 for loads.
- Load extraction from the byte lane selected by addr[1:0]:
  - lb: sign-extend. lbu: zero-extend.
  - lh: sign-extend. lhu: zero-extend.
  - lw: full word.
  - funct3 110/111 treated as lw.
- wb_data for loads = extracted data when write_source=1, else alu_result.
- Stores produce wb_valid=1 with wb_en_write_reg as supplied by upstream (0 for well-formed stores).
- in_valid=0: wb_valid=0 next cycle; other wb_* don't-care but held.

## Timing
- Reset values:
  - state=IDLE
  - dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0
  - wb_valid=0, wb_rd=0, wb_en_write_reg=0, wb_data=0
  - misalign=0
- Latency:
  - Non-memory op: wb at N+1.
  - Memory op accepted in cycle N: dmem_req at N+1. With ack at N+1+k (k≥0), wb_valid at N+2+k.
- Minimum memory-op throughput: one per 2 cycles.
- dmem_ack outside BUSY is ignored.
- rst while BUSY: next cycle state=IDLE and dmem_req=0. A late ack is ignored and produces no wb entry.

## Structure
- Shared package rv_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - mem_state_t enum {IDLE, BUSY}.
- Sub-module mem_load_align: combinational extract/extend of dmem_rdata from funct3 and addr[1:0].

## Test plan
- ALU op, alu_result=0x1234, rd=5, write_source=0:
  - wb_data=0x1234, wb_rd=5 one cycle later.
  - dmem_req never set.
- lb at 0x103, dmem_rdata=0x80FF_FF00, ack one cycle after req:
  - stall high 2 cycles; dmem_addr=0x100.
  - wb_data=0xFFFF_FF80.
  - lbu at the same address gives wb_data=0x0000_0080.
- sh at 0x202, rdata2=0xDEAD_BEEF:
  - dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1.
- lw at 0x006:
  - no dmem_req; misalign pulse; wb_en_write_reg=0.
- lw with ack delayed 3 cycles:
  - dmem_* stable throughout; stall high 4 cycles.
  - wb_valid exactly once.
- rst asserted while BUSY, then ack arrives:
  - dmem_req=0 the cycle after rst.
  - no wb_valid produced.
